// File: rtl/fib_controller.sv
// fib_controller: sequencing FSM for the Fibonacci datapath.
// It drives the select codes and the shared clear of the A/B register
// cells and counts the remaining iterations. When done pulses,
// register A holds F(n).
module fib_controller #(
    parameter int N_W = 5
) (
    input  logic           clk,
    input  logic           CLR,
    input  logic           start,
    input  logic [N_W-1:0] n,
    output logic [1:0]     sel_a,
    output logic [1:0]     sel_b,
    output logic           clr_regs,
    output logic           busy,
    output logic           done,
    output logic [N_W-1:0] iter
);

    // Select codes understood by the register cells
    localparam logic [1:0] SEL_HOLD       = 2'b00;
    localparam logic [1:0] SEL_LOAD_ONE   = 2'b01;
    localparam logic [1:0] SEL_LOAD_OTHER = 2'b10;
    localparam logic [1:0] SEL_LOAD_SUM   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_INIT = 2'b01,
        S_CALC = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t         state_q, state_d;
    logic [N_W-1:0] cnt_q, cnt_d;

    // State and iteration counter registers; CLR returns to IDLE with counter 0
    always_ff @(posedge clk) begin
        if (CLR) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = n;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                // n=0 needs no iterations: A=0 is already F(0)
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                // Guarded decrement so the counter can never wrap
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (cnt_q <= 1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore output decode from the state register
    always_comb begin
        sel_a    = SEL_HOLD;
        sel_b    = SEL_HOLD;
        clr_regs = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
            end
            S_INIT: begin
                clr_regs = 1'b1;
                sel_b    = SEL_LOAD_ONE;
                busy     = 1'b1;
            end
            S_CALC: begin
                sel_a = SEL_LOAD_OTHER;
                sel_b = SEL_LOAD_SUM;
                busy  = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign iter = cnt_q;

endmodule

// File: tb/tb_fib_controller.sv
// tb_fib_controller: table-driven runs, hand-written corner sequences and
// randomized stimulus, all checked cycle by cycle against a reference model
// that tracks "cycles since accepted start" plus a behavioural A/B datapath.
`timescale 1ns/1ps
module tb_fib_controller;

    localparam int N_W = 5;

    logic           clk;
    logic           clr_i;
    logic           start_i;
    logic [N_W-1:0] n_i;
    logic [1:0]     sel_a;
    logic [1:0]     sel_b;
    logic           clr_regs;
    logic           busy;
    logic           done;
    logic [N_W-1:0] iter;

    int total = 0;
    int bad   = 0;

    // Reference model: mt = cycles since the accepted start (0 = idle),
    // mn = latched n. INIT at mt=1, CALC for mt=2..mn+1, DONE at mt=mn+2.
    int mt = 0;
    int mn = 0;

    // Behavioural datapath registers driven by the controller outputs
    int da = 0;
    int db = 0;

    fib_controller #(.N_W(N_W)) dut (
        .clk      (clk),
        .CLR      (clr_i),
        .start    (start_i),
        .n        (n_i),
        .sel_a    (sel_a),
        .sel_b    (sel_b),
        .clr_regs (clr_regs),
        .busy     (busy),
        .done     (done),
        .iter     (iter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register cells for A and B
    always @(posedge clk) begin
        if (clr_i) begin
            da <= 0;
            db <= 0;
        end else if (clr_regs) begin
            da <= 0;
            db <= (sel_b == 2'b01) ? 1 : 0;
        end else begin
            case (sel_a)
                2'b01:   da <= 1;
                2'b10:   da <= db;
                2'b11:   da <= da + db;
                default: da <= da;
            endcase
            case (sel_b)
                2'b01:   db <= 1;
                2'b10:   db <= da;
                2'b11:   db <= da + db;
                default: db <= db;
            endcase
        end
    end

    function automatic int fib(input int k);
        int a, b, t;
        a = 0;
        b = 1;
        for (int i = 0; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model on the edge, compare away from the edge
    task automatic step();
        int e_sa, e_sb, e_clr, e_busy, e_done, e_iter;
        @(posedge clk);
        if (clr_i) begin
            mt = 0;
        end else if (mt == 0) begin
            if (start_i) begin
                mt = 1;
                mn = int'(n_i);
            end
        end else if (mt == mn + 2) begin
            mt = 0;
        end else begin
            mt++;
        end
        @(negedge clk);
        e_sa = 0; e_sb = 0; e_clr = 0; e_busy = 0; e_done = 0; e_iter = 0;
        if (mt == 0) begin
        end else if (mt == mn + 2) begin
            e_done = 1;
            e_busy = 1;
        end else if (mt == 1) begin
            e_clr  = 1;
            e_sb   = 1;
            e_busy = 1;
            e_iter = mn;
        end else begin
            e_sa   = 2;
            e_sb   = 3;
            e_busy = 1;
            e_iter = mn - (mt - 2);
        end
        chk("sel_a", int'(sel_a), e_sa);
        chk("sel_b", int'(sel_b), e_sb);
        chk("clr_regs", int'(clr_regs), e_clr);
        chk("busy", int'(busy), e_busy);
        chk("done", int'(done), e_done);
        chk("iter", int'(iter), e_iter);
        if (e_done == 1) chk("A_at_done", da, fib(mn));
    endtask

    // Accept one start with n=nn, wait (bounded) for done, check latency and A
    task automatic run(input int nn, input int lat, input int a, input string nm);
        int cyc;
        start_i = 1'b1;
        n_i     = N_W'(nn);
        step();
        start_i = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 60) begin
            step();
            cyc++;
        end
        chk({nm, "_latency"}, cyc, lat);
        if (done === 1'b1) chk({nm, "_A"}, da, a);
        step();
    endtask

    typedef struct {
        int    n;
        int    lat;
        int    a;
        string name;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int cyc;
        int seen_done;

        tbl[0] = '{0, 2, 0, "n0"};
        tbl[1] = '{1, 3, 1, "n1"};
        tbl[2] = '{5, 7, 5, "n5"};
        tbl[3] = '{10, 12, 55, "n10"};
        tbl[4] = '{31, 33, 1346269, "n31"};
        tbl[5] = '{2, 4, 1, "n2"};

        // Reset with start held high: CLR must dominate
        clr_i   = 1'b1;
        start_i = 1'b1;
        n_i     = 5'd5;
        step();
        step();
        clr_i   = 1'b0;
        start_i = 1'b0;
        step();

        // Table-driven single runs
        for (int i = 0; i < 6; i++) begin
            run(tbl[i].n, tbl[i].lat, tbl[i].a, tbl[i].name);
            step();
        end

        // Start pulses with a different n during INIT, CALC and DONE are ignored
        start_i = 1'b1;
        n_i     = 5'd6;
        step();
        cyc = 1;
        while (done !== 1'b1 && cyc < 60) begin
            start_i = (cyc == 1 || cyc == 4) ? 1'b1 : 1'b0;
            n_i     = 5'd2;
            step();
            cyc++;
        end
        chk("ignored_start_latency", cyc, 8);
        chk("ignored_start_A", da, 8);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("idle_after_done_busy", int'(busy), 0);
        step();

        // Held start: INIT reappears exactly n+3 cycles after the previous INIT
        start_i = 1'b1;
        n_i     = 5'd3;
        step();
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (clr_regs !== 1'b1 && cyc < 30);
        chk("held_start_spacing", cyc, 6);
        start_i = 1'b0;
        for (int i = 0; i < 8; i++) step();

        // CLR during the 3rd CALC cycle of n=8 aborts without a done pulse
        start_i = 1'b1;
        n_i     = 5'd8;
        step();
        start_i = 1'b0;
        step();
        step();
        step();
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_iter", int'(iter), 0);
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done === 1'b1) seen_done = 1;
        end
        chk("abort_no_done", seen_done, 0);
        run(2, 4, 1, "after_abort_n2");

        // Randomized stimulus against the reference model
        for (int i = 0; i < 600; i++) begin
            start_i = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
            n_i     = N_W'($urandom_range(0, 12));
            clr_i   = ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0;
            step();
        end
        clr_i   = 1'b0;
        start_i = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
